// File: rtl/astar_neighbor_sequencer_if.sv
// Probe port (map + closed set) and neighbour hand-off bundle of the A* neighbour sequencer.
// The master side is the sequencer; the slave side is the map/closed-set memories plus the open-list update logic.
interface astar_neighbor_sequencer_if #(
    parameter int COORD_W = 8,
    parameter int COST_W  = 8
);
    logic               probe_en;
    logic [COORD_W-1:0] probe_x;
    logic [COORD_W-1:0] probe_y;
    logic               map_obstacle;
    logic               closed_hit;
    logic               nb_valid;
    logic               nb_ready;
    logic [COORD_W-1:0] nb_x;
    logic [COORD_W-1:0] nb_y;
    logic [2:0]         nb_dir;
    logic [COST_W-1:0]  nb_cost;

    modport master (
        output probe_en, probe_x, probe_y,
        input  map_obstacle, closed_hit,
        output nb_valid, nb_x, nb_y, nb_dir, nb_cost,
        input  nb_ready
    );

    modport slave (
        input  probe_en, probe_x, probe_y,
        output map_obstacle, closed_hit,
        input  nb_valid, nb_x, nb_y, nb_dir, nb_cost,
        output nb_ready
    );
endinterface

// File: rtl/astar_neighbor_sequencer.sv
// Expands one A* node: walks its 8 neighbours in the order NW,N,NE,E,SE,S,SW,W.
// Out-of-grid neighbours are dropped, the rest are probed, and free ones are offered with their step cost.
module astar_neighbor_sequencer #(
    parameter int GRID_W        = 40,
    parameter int GRID_H        = 40,
    parameter int COORD_W       = 8,
    parameter int COST_W        = 8,
    parameter int COST_STRAIGHT = 10,
    parameter int COST_DIAG     = 14
) (
    input  logic                       sync,
    input  logic                       reset,
    input  logic                       start,
    input  logic [COORD_W-1:0]         cur_x,
    input  logic [COORD_W-1:0]         cur_y,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [3:0]                 nb_count,
    astar_neighbor_sequencer_if.master nbIf
);
    typedef enum logic [2:0] {IDLE, BOUND, WAIT, EMIT, DONE} stateType;

    localparam logic [COORD_W-1:0] xMax         = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] yMax         = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] noneCoord    = '1;
    localparam logic [COORD_W-1:0] coordOne     = COORD_W'(1);
    localparam logic [COST_W-1:0]  costStraight = COST_W'(COST_STRAIGHT);
    localparam logic [COST_W-1:0]  costDiag     = COST_W'(COST_DIAG);

    stateType           state;
    stateType           nextState;
    logic [COORD_W-1:0] curX;
    logic [COORD_W-1:0] curY;
    logic [2:0]         dirReg;
    logic [3:0]         nbCountReg;
    logic               errFlag;
    logic [COORD_W-1:0] nbXReg;
    logic [COORD_W-1:0] nbYReg;
    logic [2:0]         nbDirReg;
    logic [COST_W-1:0]  nbCostReg;

    logic               stepW, stepE, stepN, stepS;
    logic [COORD_W-1:0] candX, candY;
    logic               candOob;
    logic               startOutOfRange;
    logic               startAccept, advance, loadNb, handshake;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        stepW = 1'b0;
        stepE = 1'b0;
        stepN = 1'b0;
        stepS = 1'b0;
        case (dirReg)
            3'd0:    begin stepW = 1'b1; stepN = 1'b1; end
            3'd1:    stepN = 1'b1;
            3'd2:    begin stepE = 1'b1; stepN = 1'b1; end
            3'd3:    stepE = 1'b1;
            3'd4:    begin stepE = 1'b1; stepS = 1'b1; end
            3'd5:    stepS = 1'b1;
            3'd6:    begin stepW = 1'b1; stepS = 1'b1; end
            default: stepW = 1'b1;
        endcase
    end

    // No wrap-around: an edge cell stepping off the grid is simply dropped.
    assign candX   = stepW ? curX - coordOne : (stepE ? curX + coordOne : curX);
    assign candY   = stepN ? curY - coordOne : (stepS ? curY + coordOne : curY);
    assign candOob = (stepW && curX == '0) || (stepE && curX == xMax) ||
                     (stepN && curY == '0) || (stepS && curY == yMax);

    assign startOutOfRange = (cur_x > xMax) || (cur_y > yMax);
    assign handshake       = (state == EMIT) && nbIf.nb_ready;

    always_comb begin
        nextState     = state;
        nbIf.probe_en = 1'b0;
        startAccept   = 1'b0;
        advance       = 1'b0;
        loadNb        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    startAccept = 1'b1;
                    nextState   = startOutOfRange ? DONE : BOUND;
                end
            end
            BOUND: begin
                if (candOob) begin
                    advance = 1'b1;
                end else begin
                    nbIf.probe_en = 1'b1;
                    nextState     = WAIT;
                end
            end
            WAIT: begin
                if (nbIf.map_obstacle || nbIf.closed_hit) begin
                    advance = 1'b1;
                end else begin
                    loadNb    = 1'b1;
                    nextState = EMIT;
                end
            end
            EMIT:    advance   = nbIf.nb_ready;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (advance) begin
            nextState = (dirReg == 3'd7) ? DONE : BOUND;
        end
    end

    // NOTE: synchronous reset, and sequential state is only ever written with non-blocking assignments.
    always_ff @(posedge sync) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge sync) begin
        if (reset) begin
            curX       <= '0;
            curY       <= '0;
            dirReg     <= '0;
            nbCountReg <= '0;
            errFlag    <= 1'b0;
            nbXReg     <= noneCoord;
            nbYReg     <= noneCoord;
            nbDirReg   <= '0;
            nbCostReg  <= '0;
        end else begin
            if (startAccept) begin
                curX       <= cur_x;
                curY       <= cur_y;
                dirReg     <= '0;
                nbCountReg <= '0;
                errFlag    <= startOutOfRange;
            end
            if (advance && dirReg != 3'd7) begin
                dirReg <= dirReg + 3'd1;
            end
            if (loadNb) begin
                nbXReg    <= candX;
                nbYReg    <= candY;
                nbDirReg  <= dirReg;
                nbCostReg <= dirReg[0] ? costStraight : costDiag;
            end
            if (handshake) begin
                nbCountReg <= nbCountReg + 4'd1;
            end
        end
    end

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign err           = done && errFlag;
    assign nb_count      = nbCountReg;
    assign nbIf.probe_x  = nbIf.probe_en ? candX : noneCoord;
    assign nbIf.probe_y  = nbIf.probe_en ? candY : noneCoord;
    assign nbIf.nb_valid = (state == EMIT);
    assign nbIf.nb_x     = nbXReg;
    assign nbIf.nb_y     = nbYReg;
    assign nbIf.nb_dir   = nbDirReg;
    assign nbIf.nb_cost  = nbCostReg;
endmodule

// File: tb/tb_astar_neighbor_sequencer.sv
// Self-checking bench for astar_neighbor_sequencer: directed corner cases plus random maps
// compared against a direction-table reference model of one node expansion.
module tb_astar_neighbor_sequencer;
    localparam int GW = 40;
    localparam int GH = 40;

    logic       sync = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cur_x = '0;
    logic [7:0] cur_y = '0;
    logic       busy, done, err;
    logic [3:0] nb_count;

    astar_neighbor_sequencer_if #(.COORD_W(8), .COST_W(8)) ifc ();

    astar_neighbor_sequencer #(
        .GRID_W(GW), .GRID_H(GH), .COORD_W(8), .COST_W(8),
        .COST_STRAIGHT(10), .COST_DIAG(14)
    ) dut (
        .sync(sync), .reset(reset), .start(start), .cur_x(cur_x), .cur_y(cur_y),
        .busy(busy), .done(done), .err(err), .nb_count(nb_count), .nbIf(ifc.master)
    );

    always #5 sync = ~sync;

    typedef struct { int x; int y; int dir; int cost; } nbRec;

    nbRec expQ[$];
    nbRec obsQ[$];
    bit   obst[GW][GH];
    bit   closedSet[GW][GH];
    int   stallPlan[$];

    int testsRun = 0;
    int testsFailed = 0;

    // Monitor state (written only by the monitor process).
    int         cycleCnt = 0, doneCount = 0, doneCycle = 0, doneNbCount = 0, doneErr = 0;
    int         probeCount = 0, probeDouble = 0, stabErrors = 0, strayErr = 0;
    logic       prevValid = 1'b0, prevReady = 1'b0, prevProbe = 1'b0;
    logic [7:0] prevX = '0, prevY = '0, prevPx = '0, prevPy = '0, prevCost = '0;
    logic [2:0] prevDir = '0;
    bit         inEmit = 1'b0;
    int         stallCur = 0, emitIdx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor, map/closed-set responder and nb_ready driver, all sampling 1 time unit after the edge.
    always @(posedge sync) begin
        cycleCnt++;
        #1;
        if (!reset) begin
            if (prevValid && prevReady) begin
                obsQ.push_back('{int'(prevX), int'(prevY), int'(prevDir), int'(prevCost)});
            end else if (prevValid && !(ifc.nb_valid === 1'b1 && ifc.nb_x === prevX &&
                         ifc.nb_y === prevY && ifc.nb_dir === prevDir && ifc.nb_cost === prevCost)) begin
                stabErrors++;
            end
        end
        if (done === 1'b1) begin
            doneCount++;
            doneCycle   = cycleCnt + 1;
            doneNbCount = int'(nb_count);
            doneErr     = int'(err);
        end else if (err === 1'b1) begin
            strayErr++;
        end
        if (ifc.probe_en === 1'b1) begin
            probeCount++;
            if (prevProbe) probeDouble++;
        end
        if (prevProbe && int'(prevPx) < GW && int'(prevPy) < GH) begin
            ifc.map_obstacle = obst[int'(prevPx)][int'(prevPy)];
            ifc.closed_hit   = closedSet[int'(prevPx)][int'(prevPy)];
        end else begin
            ifc.map_obstacle = 1'($urandom);
            ifc.closed_hit   = 1'($urandom);
        end
        if (busy !== 1'b1) begin
            inEmit   = 1'b0;
            emitIdx  = 0;
            stallCur = 0;
        end
        if (ifc.nb_valid === 1'b1) begin
            if (!inEmit) begin
                inEmit   = 1'b1;
                stallCur = (emitIdx < stallPlan.size()) ? stallPlan[emitIdx] : 0;
                emitIdx++;
            end
            if (stallCur > 0) begin
                ifc.nb_ready = 1'b0;
                stallCur--;
            end else begin
                ifc.nb_ready = 1'b1;
                inEmit = 1'b0;
            end
        end else begin
            ifc.nb_ready = 1'($urandom);
        end
        prevValid = (ifc.nb_valid === 1'b1);
        prevReady = ifc.nb_ready;
        prevX     = ifc.nb_x;
        prevY     = ifc.nb_y;
        prevDir   = ifc.nb_dir;
        prevCost  = ifc.nb_cost;
        prevProbe = (ifc.probe_en === 1'b1);
        prevPx    = ifc.probe_x;
        prevPy    = ifc.probe_y;
    end

    task automatic clearMaps();
        for (int i = 0; i < GW; i++) begin
            for (int j = 0; j < GH; j++) begin
                obst[i][j]      = 1'b0;
                closedSet[i][j] = 1'b0;
            end
        end
    endtask

    // Reference model: neighbour table walk with per-direction cycle costs, then compare.
    task automatic runExpansion(input string tag, input int x, input int y, input bit pokeStart);
        int dxT[8];
        int dyT[8];
        int cyc, probes, nEmit, nx, ny, k, base, dc0, pc0, se0, pd0, budget, expErr, stall;
        nbRec e;
        dxT = '{-1, 0, 1, 1, 1, 0, -1, -1};
        dyT = '{-1, -1, -1, 0, 1, 1, 1, 0};
        expQ.delete();
        cyc = 0; probes = 0; nEmit = 0;
        expErr = (x >= GW || y >= GH) ? 1 : 0;
        if (expErr == 0) begin
            for (int d = 0; d < 8; d++) begin
                nx = x + dxT[d];
                ny = y + dyT[d];
                if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                    cyc += 1;
                end else begin
                    probes++;
                    if (obst[nx][ny] || closedSet[nx][ny]) begin
                        cyc += 2;
                    end else begin
                        stall = (nEmit < stallPlan.size()) ? stallPlan[nEmit] : 0;
                        e = '{nx, ny, d, (d % 2 == 0) ? 14 : 10};
                        expQ.push_back(e);
                        nEmit++;
                        cyc += 3 + stall;
                    end
                end
            end
        end
        base = obsQ.size(); dc0 = doneCount; pc0 = probeCount; se0 = stabErrors; pd0 = probeDouble;
        @(negedge sync);
        cur_x = 8'(x); cur_y = 8'(y); start = 1'b1;
        k = cycleCnt + 1;
        @(negedge sync);
        start = 1'b0; cur_x = 8'($urandom); cur_y = 8'($urandom);
        budget = 0;
        while (doneCount == dc0 && budget < 400) begin
            @(negedge sync);
            budget++;
            if (pokeStart && budget == 3) begin
                start = 1'b1;
                cur_x = 8'($urandom_range(0, GW - 1));
                cur_y = 8'($urandom_range(0, GH - 1));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, (doneCount != dc0) ? 1 : 0, 1);
        check({tag, " done_cycle"}, doneCycle, k + 1 + cyc);
        check({tag, " nb_count"}, doneNbCount, nEmit);
        check({tag, " err"}, doneErr, expErr);
        check({tag, " probes"}, probeCount - pc0, probes);
        check({tag, " probe_overlap"}, probeDouble - pd0, 0);
        check({tag, " stable"}, stabErrors - se0, 0);
        check({tag, " handshakes"}, obsQ.size() - base, expQ.size());
        for (int i = 0; i < expQ.size() && base + i < obsQ.size(); i++) begin
            check({tag, $sformatf(" nb%0d_x", i)}, obsQ[base + i].x, expQ[i].x);
            check({tag, $sformatf(" nb%0d_y", i)}, obsQ[base + i].y, expQ[i].y);
            check({tag, $sformatf(" nb%0d_dir", i)}, obsQ[base + i].dir, expQ[i].dir);
            check({tag, $sformatf(" nb%0d_cost", i)}, obsQ[base + i].cost, expQ[i].cost);
        end
        if (pokeStart) begin
            repeat (5) @(negedge sync);
            check({tag, " single_done"}, doneCount - dc0, 1);
            check({tag, " idle_after"}, busy, 0);
        end
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " err"}, err, 0);
        check({tag, " nb_count"}, nb_count, 0);
        check({tag, " probe_en"}, ifc.probe_en, 0);
        check({tag, " probe_x"}, ifc.probe_x, 8'hFF);
        check({tag, " probe_y"}, ifc.probe_y, 8'hFF);
        check({tag, " nb_valid"}, ifc.nb_valid, 0);
        check({tag, " nb_x"}, ifc.nb_x, 8'hFF);
        check({tag, " nb_y"}, ifc.nb_y, 8'hFF);
        check({tag, " nb_dir"}, ifc.nb_dir, 0);
        check({tag, " nb_cost"}, ifc.nb_cost, 0);
    endtask

    initial begin
        int dc0, waitCnt, rx, ry;
        clearMaps();
        reset = 1'b1;
        repeat (3) @(negedge sync);
        checkResetValues("por");
        reset = 1'b0;
        @(negedge sync);

        stallPlan = '{};
        runExpansion("interior", 5, 5, 1'b0);
        runExpansion("corner00", 0, 0, 1'b0);

        obst[38][38] = 1'b1;
        closedSet[39][38] = 1'b1;
        runExpansion("corner3939", 39, 39, 1'b0);
        clearMaps();

        stallPlan = '{0, 4};
        runExpansion("backpressure", 5, 5, 1'b0);
        stallPlan = '{};

        runExpansion("range_x", 40, 5, 1'b0);
        runExpansion("range_y", 7, 200, 1'b0);
        runExpansion("start_busy", 20, 17, 1'b1);

        // Reset while a neighbour is being offered and held off by the consumer.
        stallPlan = '{30};
        @(negedge sync);
        cur_x = 8'd5; cur_y = 8'd5; start = 1'b1;
        @(negedge sync);
        start = 1'b0;
        waitCnt = 0;
        while (ifc.nb_valid !== 1'b1 && waitCnt < 50) begin
            @(negedge sync);
            waitCnt++;
        end
        check("rst_emit reached", ifc.nb_valid, 1);
        dc0 = doneCount;
        reset = 1'b1;
        @(negedge sync);
        reset = 1'b0;
        checkResetValues("rst_emit");
        repeat (30) @(negedge sync);
        check("rst_emit no_done", doneCount - dc0, 0);
        check("rst_emit idle", busy, 0);
        stallPlan = '{};

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < GW; i++) begin
                for (int j = 0; j < GH; j++) begin
                    obst[i][j]      = ($urandom_range(0, 3) == 0);
                    closedSet[i][j] = ($urandom_range(0, 4) == 0);
                end
            end
            stallPlan.delete();
            for (int i = 0; i < 8; i++) stallPlan.push_back($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
                rx = $urandom_range(40, 255);
                ry = $urandom_range(0, 255);
            end else begin
                rx = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : GW - 1) : $urandom_range(0, GW - 1);
                ry = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : GH - 1) : $urandom_range(0, GH - 1);
            end
            runExpansion($sformatf("rand%0d", t), rx, ry, 1'b0);
        end

        check("stray_err", strayErr, 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
